dma_engine: RTL and testbench
=============================

DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 Parameter NCH, default 2, SHALL set the channel count; channel 0 has highest priority.
REQ-002 Parameter LEN_W, default 8, SHALL set the length field width; a channel transfers ch_len+1 bytes (1..2^LEN_W).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 apu_cycle  in  1  APU phase strobe; bus accesses align to it.
REQ-006 rw_i / cpu_addr_i / cpu_data_i  in  1/16/8  CPU bus request (rw 1=read).
REQ-007 bus_data_i  in  8  read data returned by the system bus.
REQ-008 cpu_addr_o / cpu_data_o / rw_o  out  16/8/1  muxed bus request to the system.
REQ-009 halt  out  1  stalls the CPU while the engine owns the bus.
REQ-010 ch_start  in  NCH  per-channel start pulse.
REQ-011 ch_src / ch_dst  in  NCH*16 each  per-channel source and destination address.
REQ-012 ch_len  in  NCH*LEN_W  per-channel byte count minus one.
REQ-013 ch_mode  in  NCH*2  bit0 1=copy (read src, write dst), 0=fetch-only; bit1 1=increment dst.
REQ-014 ch_busy / ch_done / ch_data_valid  out  NCH each  busy level, one-cycle completion pulse, one-cycle fetched-byte strobe.
REQ-015 ch_data  out  8  last fetched byte, shared by all channels.

Function
REQ-016 ch_start[i] with ch_busy[i]=0 SHALL latch src, dst, len and mode for channel i and set ch_busy[i] on the next cycle; a start while busy SHALL be ignored.
REQ-017 The engine FSM SHALL use states IDLE, STALL, ALIGN, FETCH and XFER.
REQ-018 IDLE->STALL when any channel is pending; STALL->FETCH on the first cycle with rw_i=1 and apu_cycle=1; ALIGN->FETCH on the first cycle with apu_cycle=1.
REQ-019 The engine SHALL arbitrate on entry to FETCH: the lowest-index pending channel wins, and a byte once started SHALL never be preempted.
REQ-020 FETCH SHALL drive cpu_addr_o=src of the winner and rw_o=1, register bus_data_i into ch_data at the end of the cycle, and post-increment src modulo 2^16.
REQ-021 XFER for a copy channel SHALL drive cpu_addr_o=dst, rw_o=0 and cpu_data_o=ch_data, then increment dst modulo 2^16 when mode bit1=1.
REQ-022 XFER for a fetch-only channel SHALL pulse ch_data_valid[winner], leave rw_o=1 and pass cpu_addr_i through.
REQ-023 On leaving XFER the engine SHALL decrement the winner's count.
REQ-024 If the winner's count was zero on leaving XFER, the engine SHALL pulse ch_done and clear ch_busy in the same cycle.
REQ-025 XFER->ALIGN if any channel is still pending; otherwise XFER->IDLE.
REQ-026 halt SHALL be 1 in every state except IDLE.
REQ-027 In STALL and ALIGN the engine SHALL pass cpu_addr_i through and drive rw_o=1.
REQ-028 In IDLE, rw_o, cpu_addr_o and cpu_data_o SHALL equal rw_i, cpu_addr_i and cpu_data_i.
REQ-029 A start arriving for a higher-priority channel mid-block SHALL take the bus at the next FETCH; the lower channel resumes afterwards with its addresses and count intact.
REQ-030 A ch_start in the same cycle as that channel's ch_done SHALL be ignored.
REQ-031 Address wrap: src or dst at 16'hFFFF SHALL increment to 16'h0000.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force FSM=IDLE and clear ch_busy, ch_done, ch_data_valid, ch_data and all channel registers.
REQ-033 Under reset, halt SHALL be 0 and outputs SHALL pass the CPU bus through.
REQ-034 Reset asserted mid-transfer SHALL abandon the byte, with no done pulse and no write after release.

Configuration
REQ-035 With DMA_ABORT_EN defined, input ch_abort (NCH) SHALL exist.
REQ-036 ch_abort[i] SHALL cancel channel i: an in-flight byte completes its XFER, then ch_busy[i] clears with no ch_done.
REQ-037 Without DMA_ABORT_EN, ch_abort SHALL not exist and channels SHALL always run to completion.

Verification
REQ-038 ch0 copy, src=16'h0200, dst=16'h2004, len=255, bit1=0 -> 256 reads of 0200..02FF, 256 writes to 2004, one ch_done[0], halt low afterward.
REQ-039 ch1 fetch-only, src=16'hC000, len=0, rw_i held 0 for 5 cycles -> STALL held; after rw_i=1 with apu_cycle=1: one FETCH of C000, ch_data_valid[1] with ch_data=bus byte, ch_done[1].
REQ-040 ch1 copy, len=3, running; ch0 fetch-only started after byte 1 -> order: ch1 bytes 0-1, ch0 byte, ch1 bytes 2-3; two done pulses.
REQ-041 Copy with src=16'hFFFF, dst=16'hFFFF, bit1=1, len=1 -> reads FFFF then 0000; writes FFFF then 0000.
REQ-042 rst_n=0 during XFER of byte 10 -> halt 0 on the next cycle, ch_busy 0, no further writes.
REQ-043 With DMA_ABORT_EN: ch_abort[0] at byte 4 of a 16-byte copy -> byte 4 write completes, ch_busy[0] clears, ch_done[0] stays 0.

Source files
------------

// File: rtl/dma_engine_if.sv
// dma_engine_if: the CPU-side request, the muxed system-bus request and the
// APU phase strobe shared between the DMA engine and the rest of the system.
// The engine connects through the master modport; the system side (or a
// testbench) uses the slave modport.
interface dma_engine_if;
  logic        apu_cycle;
  logic        rw_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_data_i;
  logic [7:0]  bus_data_i;
  logic [15:0] cpu_addr_o;
  logic [7:0]  cpu_data_o;
  logic        rw_o;
  logic        halt;

  modport master (
    input  apu_cycle, rw_i, cpu_addr_i, cpu_data_i, bus_data_i,
    output cpu_addr_o, cpu_data_o, rw_o, halt
  );

  modport slave (
    output apu_cycle, rw_i, cpu_addr_i, cpu_data_i, bus_data_i,
    input  cpu_addr_o, cpu_data_o, rw_o, halt
  );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: multi-channel byte DMA that steals the CPU bus one byte at a
// time. Each byte is a FETCH (read src) followed by an XFER (write dst for
// copy channels, or a data strobe for fetch-only channels). Channel 0 has the
// highest priority; arbitration happens only when a new byte starts.
// Optional feature: define DMA_ABORT_EN to add the per-channel ch_abort input.
module dma_engine #(
  parameter int NCH   = 2,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_engine_if.master         bus,
  input  logic [NCH-1:0]       ch_start,
  input  logic [NCH*16-1:0]    ch_src,
  input  logic [NCH*16-1:0]    ch_dst,
  input  logic [NCH*LEN_W-1:0] ch_len,
  input  logic [NCH*2-1:0]     ch_mode,
`ifdef DMA_ABORT_EN
  input  logic [NCH-1:0]       ch_abort,
`endif
  output logic [NCH-1:0]       ch_busy,
  output logic [NCH-1:0]       ch_done,
  output logic [NCH-1:0]       ch_data_valid,
  output logic [7:0]           ch_data
);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {IDLE, STALL, ALIGN, FETCH, XFER} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [15:0]      src_q [NCH];
  logic [15:0]      src_d [NCH];
  logic [15:0]      dst_q [NCH];
  logic [15:0]      dst_d [NCH];
  logic [LEN_W-1:0] len_q [NCH];
  logic [LEN_W-1:0] len_d [NCH];
  logic [1:0]       mode_q [NCH];
  logic [1:0]       mode_d [NCH];
  logic [NCH-1:0]   busy_q, busy_d;
  logic [NCH-1:0]   done_q, done_d;
  logic [NCH-1:0]   valid_q, valid_d;
  logic [NCH-1:0]   abort_q, abort_d;
  logic [NCH-1:0]   pend;
  logic [7:0]       data_q, data_d;

  // Lowest-index pending channel wins the next byte.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NCH-1:0] p);
    pick_winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (p[i]) pick_winner = IDX_W'(i);
    end
  endfunction

  // Next-state logic: channel register loads, aborts and the byte sequencer.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = '0;
    valid_d = '0;
    abort_d = abort_q;
    data_d  = data_q;
    pend    = busy_q;

    // A start is taken only by an idle channel that is not in its done cycle.
    for (int i = 0; i < NCH; i++) begin
      if (ch_start[i] && !busy_q[i] && !done_q[i]) begin
        busy_d[i] = 1'b1;
        src_d[i]  = ch_src[i*16 +: 16];
        dst_d[i]  = ch_dst[i*16 +: 16];
        len_d[i]  = ch_len[i*LEN_W +: LEN_W];
        mode_d[i] = ch_mode[i*2 +: 2];
      end
    end

`ifdef DMA_ABORT_EN
    // The channel owning an in-flight byte finishes that byte first.
    for (int i = 0; i < NCH; i++) begin
      if (ch_abort[i] && busy_q[i]) begin
        if ((state_q == FETCH || state_q == XFER) && cur_q == IDX_W'(i)) begin
          abort_d[i] = 1'b1;
        end else begin
          busy_d[i] = 1'b0;
          pend[i]   = 1'b0;
        end
      end
    end
`endif

    case (state_q)
      IDLE: begin
        if (|pend) state_d = STALL;
      end
      STALL: begin
        if (pend == '0) begin
          state_d = IDLE;
        end else if (bus.rw_i && bus.apu_cycle) begin
          state_d = FETCH;
          cur_d   = pick_winner(pend);
        end
      end
      ALIGN: begin
        if (pend == '0) begin
          state_d = IDLE;
        end else if (bus.apu_cycle) begin
          state_d = FETCH;
          cur_d   = pick_winner(pend);
        end
      end
      FETCH: begin
        data_d         = bus.bus_data_i;
        src_d[cur_q]   = src_q[cur_q] + 16'd1;
        valid_d[cur_q] = !mode_q[cur_q][0];
        state_d        = XFER;
      end
      XFER: begin
        if (mode_q[cur_q] == 2'b11) dst_d[cur_q] = dst_q[cur_q] + 16'd1;
        len_d[cur_q] = len_q[cur_q] - LEN_W'(1);
        if (abort_d[cur_q]) begin
          busy_d[cur_q]  = 1'b0;
          abort_d[cur_q] = 1'b0;
        end else if (len_q[cur_q] == '0) begin
          busy_d[cur_q] = 1'b0;
          done_d[cur_q] = 1'b1;
        end
        state_d = (|busy_d) ? ALIGN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and channel registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      valid_q <= '0;
      abort_q <= '0;
      data_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        src_q[i]  <= '0;
        dst_q[i]  <= '0;
        len_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      data_q  <= data_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

  // Bus mux: CPU passes through unless the engine is mid-byte; reset forces passthrough.
  always_comb begin
    bus.cpu_addr_o = bus.cpu_addr_i;
    bus.cpu_data_o = bus.cpu_data_i;
    bus.rw_o       = bus.rw_i;
    bus.halt       = 1'b0;
    if (rst_n) begin
      case (state_q)
        STALL, ALIGN: begin
          bus.rw_o = 1'b1;
          bus.halt = 1'b1;
        end
        FETCH: begin
          bus.cpu_addr_o = src_q[cur_q];
          bus.rw_o       = 1'b1;
          bus.halt       = 1'b1;
        end
        XFER: begin
          bus.halt = 1'b1;
          if (mode_q[cur_q][0]) begin
            bus.cpu_addr_o = dst_q[cur_q];
            bus.cpu_data_o = data_q;
            bus.rw_o       = 1'b0;
          end else begin
            bus.rw_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_busy       = busy_q;
  assign ch_done       = done_q;
  assign ch_data_valid = valid_q;
  assign ch_data       = data_q;
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed-sequence bench for dma_engine with randomized
// addresses, APU phase and bus data. A negedge monitor logs every engine read
// and write seen on the muxed bus; expectations come from a byte-level model
// of each channel (address sequence, memory contents, priority order).
module tb_dma_engine;
  localparam int NCH   = 2;
  localparam int LEN_W = 8;
  localparam logic [15:0] SENTINEL = 16'h7E7E;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       ch_start;
  logic [NCH*16-1:0]    ch_src;
  logic [NCH*16-1:0]    ch_dst;
  logic [NCH*LEN_W-1:0] ch_len;
  logic [NCH*2-1:0]     ch_mode;
`ifdef DMA_ABORT_EN
  logic [NCH-1:0]       ch_abort;
`endif
  logic [NCH-1:0]       ch_busy;
  logic [NCH-1:0]       ch_done;
  logic [NCH-1:0]       ch_data_valid;
  logic [7:0]           ch_data;
  logic [7:0]           seed;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] rd_log[$];
  logic [23:0] wr_log[$];
  logic [7:0]  valid_data[$];
  int          valid_ch[$];
  int          done_cnt [NCH];
  logic [15:0] exp_rd[$];
  logic [23:0] exp_wr[$];

  dma_engine_if bus_if();

  dma_engine #(.NCH(NCH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .ch_start      (ch_start),
    .ch_src        (ch_src),
    .ch_dst        (ch_dst),
    .ch_len        (ch_len),
    .ch_mode       (ch_mode),
`ifdef DMA_ABORT_EN
    .ch_abort      (ch_abort),
`endif
    .ch_busy       (ch_busy),
    .ch_done       (ch_done),
    .ch_data_valid (ch_data_valid),
    .ch_data       (ch_data)
  );

  always #5 clk = ~clk;

  // Memory model: every address holds a seed-scrambled byte.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], a[15]} ^ seed;
  endfunction

  assign bus_if.bus_data_i = mem_byte(bus_if.cpu_addr_o);

  // Random APU phase and CPU write data, changed just after each rising edge.
  initial begin
    bus_if.apu_cycle  = 1'b0;
    bus_if.cpu_addr_i = SENTINEL;
    bus_if.cpu_data_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      bus_if.apu_cycle  = ($urandom_range(0, 2) == 0);
      bus_if.cpu_data_i = 8'($urandom);
    end
  end

  // Bus monitor: engine reads/writes, done pulses and fetch strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.halt && !bus_if.rw_o)
        wr_log.push_back({bus_if.cpu_addr_o, bus_if.cpu_data_o});
      else if (bus_if.halt && bus_if.rw_o && bus_if.cpu_addr_o != bus_if.cpu_addr_i)
        rd_log.push_back(bus_if.cpu_addr_o);
      for (int i = 0; i < NCH; i++) begin
        if (ch_done[i]) done_cnt[i]++;
        if (ch_data_valid[i]) begin
          valid_ch.push_back(i);
          valid_data.push_back(ch_data);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [15:0] src, input logic [15:0] dst,
                               input logic [LEN_W-1:0] len, input logic [1:0] mode);
    @(posedge clk);
    #1;
    ch_src[ch*16 +: 16]       = src;
    ch_dst[ch*16 +: 16]       = dst;
    ch_len[ch*LEN_W +: LEN_W] = len;
    ch_mode[ch*2 +: 2]        = mode;
    ch_start[ch]              = 1'b1;
    @(posedge clk);
    #1;
    ch_start[ch] = 1'b0;
  endtask

  task automatic clearLogs();
    @(posedge clk);
    #1;
    rd_log.delete();
    wr_log.delete();
    valid_data.delete();
    valid_ch.delete();
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < NCH; i++) done_cnt[i] = 0;
  endtask

  task automatic waitQuiet(input string tag, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((ch_busy != '0 || bus_if.halt) && n < budget);
    checkOutput({tag, "_quiet"}, 32'(ch_busy == '0 && !bus_if.halt), 1);
  endtask

  task automatic waitLog(input string tag, input bit writes, input int count, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (((writes ? wr_log.size() : rd_log.size()) < count) && n < budget);
    checkOutput({tag, "_wait"}, 32'((writes ? wr_log.size() : rd_log.size()) >= count), 1);
  endtask

  task automatic checkLogs(input string tag);
    checkOutput({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
    for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++)
      checkOutput($sformatf("%s_rd%0d", tag, k), 32'(rd_log[k]), 32'(exp_rd[k]));
    checkOutput({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++)
      checkOutput($sformatf("%s_wr%0d", tag, k), 32'(wr_log[k]), 32'(exp_wr[k]));
  endtask

  // Directed sequence of scenarios; channel behaviour is predicted byte by byte.
  initial begin
    logic [15:0] s0, s1, d1, a;
    logic [1:0]  m1;
    int          len5;
    int          n;

    seed          = 8'($urandom);
    rst_n         = 1'b0;
    ch_start      = '0;
    ch_src        = '0;
    ch_dst        = '0;
    ch_len        = '0;
    ch_mode       = '0;
    bus_if.rw_i   = 1'b1;
`ifdef DMA_ABORT_EN
    ch_abort      = '0;
`endif
    for (int i = 0; i < NCH; i++) done_cnt[i] = 0;

    // Reset state and CPU passthrough under reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_halt", 32'(bus_if.halt), 0);
    checkOutput("rst_busy", 32'(ch_busy), 0);
    checkOutput("rst_done", 32'(ch_done), 0);
    checkOutput("rst_valid", 32'(ch_data_valid), 0);
    checkOutput("rst_data", 32'(ch_data), 0);
    checkOutput("rst_addr_pass", 32'(bus_if.cpu_addr_o), 32'(SENTINEL));
    checkOutput("rst_rw_pass", 32'(bus_if.rw_o), 1);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus_if.rw_i = 1'b0;

    // Idle passthrough of a CPU write.
    @(negedge clk);
    checkOutput("idle_rw_pass", 32'(bus_if.rw_o), 0);
    checkOutput("idle_data_pass", 32'(bus_if.cpu_data_o), 32'(bus_if.cpu_data_i));
    checkOutput("idle_halt", 32'(bus_if.halt), 0);
    @(posedge clk);
    #1;
    bus_if.rw_i = 1'b1;

    // 256-byte copy from 0200 to a fixed destination.
    clearLogs();
    for (int k = 0; k < 256; k++) begin
      a = 16'h0200 + 16'(k);
      exp_rd.push_back(a);
      exp_wr.push_back({16'h2004, mem_byte(a)});
    end
    applyStimulus(0, 16'h0200, 16'h2004, 8'd255, 2'b01);
    waitQuiet("t1", 8000);
    checkLogs("t1");
    checkOutput("t1_done0", done_cnt[0], 1);
    checkOutput("t1_done1", done_cnt[1], 0);
    @(negedge clk);
    checkOutput("t1_halt_after", 32'(bus_if.halt), 0);

    // Fetch-only single byte held in STALL while the CPU is writing.
    clearLogs();
    bus_if.rw_i = 1'b0;
    applyStimulus(1, 16'hC000, 16'h0000, 8'd0, 2'b00);
    repeat (5) @(negedge clk);
    checkOutput("t2_stall_halt", 32'(bus_if.halt), 1);
    checkOutput("t2_stall_reads", rd_log.size(), 0);
    @(posedge clk);
    #1;
    bus_if.rw_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!ch_done[1] && n < 200);
    checkOutput("t2_done_seen", 32'(ch_done[1]), 1);
    // A start landing on the done cycle must be dropped.
    ch_start[1] = 1'b1;
    @(posedge clk);
    #1;
    ch_start[1] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t2_restart_ignored", 32'(ch_busy[1]), 0);
    checkOutput("t2_halt_after", 32'(bus_if.halt), 0);
    exp_rd.push_back(16'hC000);
    checkLogs("t2");
    checkOutput("t2_valid_count", valid_ch.size(), 1);
    if (valid_ch.size() > 0) begin
      checkOutput("t2_valid_ch", valid_ch[0], 1);
      checkOutput("t2_valid_data", 32'(valid_data[0]), 32'(mem_byte(16'hC000)));
    end
    checkOutput("t2_done1", done_cnt[1], 1);

    // Priority preemption: ch0 fetch-only arrives during ch1's second byte.
    clearLogs();
    s1 = 16'h4000 + 16'($urandom_range(0, 16'h0FF0));
    d1 = 16'h5000 + 16'($urandom_range(0, 16'h0FF0));
    s0 = 16'h6000 + 16'($urandom_range(0, 16'h0FF0));
    m1 = {1'($urandom), 1'b1};
    applyStimulus(1, s1, d1, 8'd3, m1);
    waitLog("t3_b1", 1'b0, 2, 200);
    applyStimulus(0, s0, 16'h0000, 8'd0, 2'b00);
    waitQuiet("t3", 400);
    exp_rd = '{s1, s1 + 16'd1, s0, s1 + 16'd2, s1 + 16'd3};
    for (int k = 0; k < 4; k++) begin
      a = s1 + 16'(k);
      exp_wr.push_back({d1 + (m1[1] ? 16'(k) : 16'd0), mem_byte(a)});
    end
    checkLogs("t3");
    checkOutput("t3_done0", done_cnt[0], 1);
    checkOutput("t3_done1", done_cnt[1], 1);
    checkOutput("t3_valid_count", valid_ch.size(), 1);
    if (valid_ch.size() > 0) begin
      checkOutput("t3_valid_ch", valid_ch[0], 0);
      checkOutput("t3_valid_data", 32'(valid_data[0]), 32'(mem_byte(s0)));
    end

    // Address wrap on both source and incrementing destination.
    clearLogs();
    applyStimulus(0, 16'hFFFF, 16'hFFFF, 8'd1, 2'b11);
    waitQuiet("t4", 200);
    exp_rd = '{16'hFFFF, 16'h0000};
    exp_wr = '{{16'hFFFF, mem_byte(16'hFFFF)}, {16'h0000, mem_byte(16'h0000)}};
    checkLogs("t4");
    checkOutput("t4_done0", done_cnt[0], 1);

    // Reset during the write of byte 10 abandons the block.
    clearLogs();
    len5 = $urandom_range(12, 40);
    s0   = 16'h4000 + 16'($urandom_range(0, 16'h0F00));
    applyStimulus(0, s0, 16'h5000, LEN_W'(len5), 2'b11);
    waitLog("t5_b10", 1'b1, 11, 400);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_halt", 32'(bus_if.halt), 0);
    checkOutput("t5_rst_busy", 32'(ch_busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t5_writes", wr_log.size(), 11);
    checkOutput("t5_done0", done_cnt[0], 0);
    checkOutput("t5_halt_after", 32'(bus_if.halt), 0);
    if (wr_log.size() > 10)
      checkOutput("t5_last_write", 32'(wr_log[10]), 32'({s0 + 16'h5000 - s0 + 16'd10, mem_byte(s0 + 16'd10)}));

`ifdef DMA_ABORT_EN
    // Abort during byte 4 of a 16-byte copy.
    clearLogs();
    s0 = 16'h4000 + 16'($urandom_range(0, 16'h0F00));
    applyStimulus(0, s0, 16'h5100, 8'd15, 2'b11);
    waitLog("t6_b4", 1'b0, 5, 200);
    ch_abort[0] = 1'b1;
    @(posedge clk);
    #1;
    ch_abort[0] = 1'b0;
    waitQuiet("t6", 200);
    for (int k = 0; k < 5; k++) begin
      exp_rd.push_back(s0 + 16'(k));
      exp_wr.push_back({16'h5100 + 16'(k), mem_byte(s0 + 16'(k))});
    end
    checkLogs("t6");
    checkOutput("t6_done0", done_cnt[0], 0);
    checkOutput("t6_busy0", 32'(ch_busy[0]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
